// File: rtl/ibus_line_buffer_if.sv
// Bus bundle for the instruction line buffer: the fetch-side ibus request/response
// and the memory-side cbus burst request/response. The slave modport is the buffer's view.
interface ibus_line_buffer_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        creq_valid;
  logic        creq_is_write;
  logic [2:0]  creq_size;
  logic [63:0] creq_addr;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic [7:0]  creq_len;
  logic [1:0]  creq_burst;
  logic        cresp_ready;
  logic        cresp_last;
  logic [63:0] cresp_data;

  modport master (
    output ireq_valid, ireq_addr, cresp_ready, cresp_last, cresp_data,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    input  creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe,
           creq_data, creq_len, creq_burst
  );

  modport slave (
    input  ireq_valid, ireq_addr, cresp_ready, cresp_last, cresp_data,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    output creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe,
           creq_data, creq_len, creq_burst
  );
endinterface

// File: rtl/ibus_line_buffer.sv
// Single-line instruction fetch buffer: zero-wait hits from one cached line,
// refilled over a cbus INCR burst read whenever a fetch misses.
module ibus_line_buffer #(
  parameter int BEATS = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  ibus_line_buffer_if.slave bus
);
  localparam int CW  = $clog2(BEATS);
  localparam int OFS = CW + 3;
  localparam logic [2:0] MSIZE8         = 3'd3;
  localparam logic [7:0] MLEN_LINE      = 8'(BEATS - 1);
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [63:0]   r_line [BEATS];
  logic [63:OFS] r_tag;
  logic [63:OFS] r_fill_tag;
  logic          r_lvalid;
  logic          r_pend_inv;
  logic [CW-1:0] r_cnt;
  logic          w_hit;
  logic          w_miss;
  logic          w_beat;
  logic          w_last;
  logic [63:0]   w_rbeat;
  logic [31:0]   w_rword;
  logic          w_unused;

  assign w_hit    = r_lvalid && (r_tag == bus.ireq_addr[63:OFS]);
  assign w_miss   = (r_state == S_IDLE) && bus.ireq_valid && !w_hit;
  assign w_beat   = (r_state == S_FILL) && bus.cresp_ready;
  assign w_last   = w_beat && bus.cresp_last;
  assign w_rbeat  = r_line[bus.ireq_addr[OFS-1:3]];
  assign w_rword  = bus.ireq_addr[2] ? w_rbeat[63:32] : w_rbeat[31:0];
  // PC alignment is fetch's job; the low address bits are deliberately ignored.
  assign w_unused = ^bus.ireq_addr[1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next            = r_state;
    bus.iresp_addr_ok = 1'b0;
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = '0;
    bus.creq_valid    = 1'b0;
    bus.creq_is_write = 1'b0;
    bus.creq_size     = '0;
    bus.creq_addr     = '0;
    bus.creq_strobe   = '0;
    bus.creq_data     = '0;
    bus.creq_len      = '0;
    bus.creq_burst    = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.ireq_valid) begin
          if (w_hit) begin
            bus.iresp_addr_ok = 1'b1;
            bus.iresp_data_ok = 1'b1;
            bus.iresp_data    = w_rword;
          end else begin
            w_next = S_FILL;
          end
        end
      end
      S_FILL: begin
        bus.creq_valid = 1'b1;
        bus.creq_size  = MSIZE8;
        bus.creq_addr  = {r_fill_tag, {OFS{1'b0}}};
        bus.creq_len   = MLEN_LINE;
        bus.creq_burst = AXI_BURST_INCR;
        if (w_last) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A flush arriving mid-burst is remembered so the completed line is born invalid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lvalid   <= 1'b0;
      r_pend_inv <= 1'b0;
      r_cnt      <= '0;
    end else if (r_state == S_IDLE) begin
      if (flush) begin
        r_lvalid <= 1'b0;
      end
      if (w_miss) begin
        r_cnt <= '0;
      end
    end else begin
      if (flush) begin
        r_pend_inv <= 1'b1;
      end
      if (w_beat) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_lvalid   <= !(r_pend_inv || flush);
        r_pend_inv <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_miss) begin
      r_fill_tag <= bus.ireq_addr[63:OFS];
    end
    if (w_beat) begin
      r_line[r_cnt] <= bus.cresp_data;
    end
    if (w_last) begin
      r_tag <= r_fill_tag;
    end
  end
endmodule

// File: tb/tb_ibus_line_buffer.sv
// Bench for ibus_line_buffer: a vector table of fetches plus hand-written corner
// sequences, a burst memory model, and a queue scoreboard on the fetch responses.
module tb_ibus_line_buffer;
  localparam int BEATS = 4;

  logic clk;
  logic resetn;
  logic flush;

  ibus_line_buffer_if bus();

  ibus_line_buffer #(.BEATS(BEATS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus)
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    int          lat;
    int          bursts;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          burstCount = 0;
  int          beatIdx = 0;
  bit          prevValid = 1'b0;
  bit          memTake = 1'b0;
  bit          memTakeLast = 1'b0;
  bit          readyPat[$];
  logic [31:0] expQ[$];
  logic [31:0] monExp;
  logic [63:0] expFillAddr = 64'h0;
  vec_t        vecs[9];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] memRead(input logic [63:0] a);
    case (a)
      64'h8000_0000: memRead = 64'h00000093_00000013;
      64'h8000_0008: memRead = 64'h2;
      64'h8000_0010: memRead = 64'h3;
      64'h8000_0018: memRead = 64'h4;
      default:       memRead = {~a[31:0], a[31:0]};
    endcase
  endfunction

  function automatic logic [31:0] memWord(input logic [63:0] a);
    logic [63:0] b;
    b = memRead({a[63:3], 3'b000});
    return a[2] ? b[63:32] : b[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Holds a fetch until data_ok, scoring latency and how many bursts it caused.
  task automatic applyStimulus(input string name, input logic [63:0] addr, input logic [31:0] data,
                               input int expLat, input int expBursts);
    int lat;
    int b0;
    bit got;
    lat = -1;
    got = 1'b0;
    b0 = burstCount;
    expFillAddr = {addr[63:5], 5'b0};
    expQ.push_back(data);
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = addr;
    for (int c = 0; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (bus.iresp_data_ok) begin
        got = 1'b1;
        lat = c;
        checkOutput({name, "_addr_ok"}, 64'(bus.iresp_addr_ok), 64'h1);
      end
      @(posedge clk);
      #1;
    end
    bus.ireq_valid = 1'b0;
    if (!got) begin
      checkOutput({name, "_timeout"}, 64'(got), 64'h1);
      if (expQ.size() > 0) void'(expQ.pop_back());
    end else begin
      checkOutput({name, "_latency"}, 64'(lat), 64'(expLat));
    end
    checkOutput({name, "_bursts"}, 64'(burstCount - b0), 64'(expBursts));
  endtask

  always @(negedge clk) begin
    if (resetn && bus.iresp_data_ok) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_data_ok", 64'(bus.iresp_data_ok), 64'h0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("iresp_data", 64'(bus.iresp_data), 64'(monExp));
      end
    end
  end

  // Memory: serves the expected line beat by beat, ready from readyPat (default 1).
  initial begin
    bus.cresp_ready = 1'b0;
    bus.cresp_last  = 1'b0;
    bus.cresp_data  = 64'h0;
    forever begin
      @(negedge clk);
      memTake     = resetn && bus.creq_valid && bus.cresp_ready;
      memTakeLast = memTake && bus.cresp_last;
      if (resetn && bus.creq_valid) begin
        checkOutput("creq_addr", bus.creq_addr, expFillAddr);
        checkOutput("creq_ctrl",
                    {42'h0, bus.creq_is_write, bus.creq_size, bus.creq_strobe, bus.creq_len, bus.creq_burst},
                    {42'h0, 1'b0, 3'd3, 8'h00, 8'd3, 2'b01});
        checkOutput("creq_wdata", bus.creq_data, 64'h0);
      end
      @(posedge clk);
      #1;
      if (memTakeLast) beatIdx = 0;
      else if (memTake) beatIdx++;
      if (!resetn) begin
        beatIdx   = 0;
        prevValid = 1'b0;
      end
      if (resetn && bus.creq_valid) begin
        if (!prevValid) burstCount++;
        prevValid       = 1'b1;
        bus.cresp_ready = (readyPat.size() > 0) ? readyPat.pop_front() : 1'b1;
        bus.cresp_data  = memRead(expFillAddr + 64'(beatIdx * 8));
        bus.cresp_last  = bus.cresp_ready && (beatIdx == BEATS - 1);
      end else begin
        prevValid       = 1'b0;
        bus.cresp_ready = 1'b0;
        bus.cresp_last  = 1'b0;
        bus.cresp_data  = 64'h0;
      end
    end
  end

  initial begin
    vecs[0] = '{64'h8000_0004, 32'h0000_0093, 5, 1};
    vecs[1] = '{64'h8000_0000, 32'h0000_0013, 0, 0};
    vecs[2] = '{64'h8000_0008, 32'h0000_0002, 0, 0};
    vecs[3] = '{64'h8000_0010, 32'h0000_0003, 0, 0};
    vecs[4] = '{64'h8000_0018, 32'h0000_0004, 0, 0};
    vecs[5] = '{64'h8000_0020, 32'h8000_0020, 5, 1};
    vecs[6] = '{64'h8000_0024, 32'h7FFF_FFDF, 0, 0};
    vecs[7] = '{64'h8000_0038, 32'h8000_0038, 0, 0};
    vecs[8] = '{64'h8000_0000, 32'h0000_0013, 5, 1};

    resetn         = 1'b0;
    flush          = 1'b0;
    bus.ireq_valid = 1'b0;
    bus.ireq_addr  = 64'h0;
    #2;
    checkOutput("reset_creq_valid", 64'(bus.creq_valid), 64'h0);
    checkOutput("reset_data_ok", 64'(bus.iresp_data_ok), 64'h0);
    checkOutput("reset_addr_ok", 64'(bus.iresp_addr_ok), 64'h0);
    #10 resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].lat, vecs[i].bursts);
    end

    readyPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    applyStimulus("backpressure", 64'h9000_0000, 32'h9000_0000, 8, 1);
    checkOutput("backpressure_pattern_used", 64'(readyPat.size()), 64'h0);
    for (int w = 0; w < 8; w++) begin
      applyStimulus($sformatf("bp_word%0d", w), 64'h9000_0000 + 64'(w * 4),
                    memWord(64'h9000_0000 + 64'(w * 4)), 0, 0);
    end

    fork
      applyStimulus("flush_fill", 64'hA000_0000, 32'hA000_0000, 10, 2);
      begin
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
    join

    fork
      applyStimulus("flush_idle_hit", 64'hA000_0008, 32'hA000_0008, 0, 0);
      begin
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
    join
    applyStimulus("after_flush_idle", 64'hA000_0008, 32'hA000_0008, 5, 1);

    expFillAddr    = 64'hB000_0000;
    bus.ireq_addr  = 64'hB000_0000;
    bus.ireq_valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("withdraw_fill_active", 64'(bus.creq_valid), 64'h1);
    bus.ireq_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    applyStimulus("withdraw_hit", 64'hB000_0010, 32'hB000_0010, 0, 0);

    expFillAddr    = 64'hC000_0000;
    bus.ireq_addr  = 64'hC000_0000;
    bus.ireq_valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("rst_fill_active", 64'(bus.creq_valid), 64'h1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("rst_async_creq_valid", 64'(bus.creq_valid), 64'h0);
    checkOutput("rst_async_data_ok", 64'(bus.iresp_data_ok), 64'h0);
    bus.ireq_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("post_reset_miss", 64'hB000_0004, 32'h4FFF_FFFF, 5, 1);

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ibus_line_buffer.md
# ibus_line_buffer

Single-line instruction fetch buffer on the responder side of the ibus. It serves `ibus_req_t` requests from the fetch stage and answers with `ibus_resp_t`. On a miss it refills one aligned line over a cbus burst read to memory. It sits between fetch (after its MMU translation) and the memory interconnect, and gives zero-wait hits for sequential fetch.

## Interface
Parameters:
- `BEATS`, default 4: 64-bit beats per line; power of two, 2..16. Line size is BEATS*8 bytes. `OFS = log2(BEATS)+3` is the offset width.

Ports:
- `clk`  in  1  clock; all state is updated on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ireq`  in  `ibus_req_t`  fetch request: `valid`, `addr` (physical). Fetch holds it until `data_ok`.
- `iresp`  out  `ibus_resp_t`  `addr_ok`, `data_ok`, `data` (u32 instruction).
- `creq`  out  `cbus_req_t`  refill request: `valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`, `burst`.
- `cresp`  in  `cbus_resp_t`  `ready`, `last`, `data` (u64 beat).
- `flush`  in  1  invalidates the line (fence.i, satp write). Single-cycle pulse.

## Operation
- State: line array `BEATS x u64`, `tag` (addr[63:OFS]), `lvalid`, `cnt` (log2(BEATS) bits), `pend_inv`, and an FSM `{IDLE, FILL}`.
- Hit is defined as `lvalid && tag == ireq.addr[63:OFS]`.
- IDLE:
  - `ireq.valid` && hit: `iresp.addr_ok = iresp.data_ok = 1` combinationally in the same cycle. `data` is word `ireq.addr[2]` (0 = bits 31:0, 1 = bits 63:32) of beat `ireq.addr[OFS-1:3]`.
  - `ireq.valid` && !hit: latch `fill_addr = {ireq.addr[63:OFS], OFS'0}`, clear `cnt`, go to FILL. `iresp` stays 0.
  - `ireq.valid` low: `iresp` is all 0.
- FILL:
  - `creq.valid = 1`, `is_write = 0`, `size = MSIZE8`, `addr = fill_addr`, `len = MLEN(BEATS)`, `burst = AXI_BURST_INCR`, `strobe = 0`, `data = 0`.
  - `iresp` is all 0 during FILL.
  - Each cycle with `cresp.ready`: write `cresp.data` into line[`cnt`], then `cnt++`.
  - Beat with `ready && last`: set `tag = fill_addr[63:OFS]` and `lvalid = !(pend_inv || flush)`, clear `pend_inv`, return to IDLE.
  - Cycles with `ready` low do not advance `cnt`; `creq` stays asserted and unchanged.
- Flush:
  - In IDLE: `lvalid <= 0` next edge. A hit presented in the same cycle as `flush` is still served (it uses the old contents).
  - In FILL: set `pend_inv`. The burst is never aborted. The filled line is left invalid, so the next request refills.
- Request withdrawn during FILL (branch, trap redirect): the fill completes and the line becomes valid. No response is owed.
- Address changes during FILL: after return to IDLE the new address is compared normally. A miss starts a new fill.
- `ireq.addr[1:0]` is not checked; misaligned-PC detection belongs to fetch.
- Reset (async, any state): FSM = IDLE, `lvalid = 0`, `pend_inv = 0`, `cnt = 0`. `creq` and `iresp` outputs are all 0 immediately. Line data is not reset.

## Timing
- Hit latency: 0 cycles (combinational `data_ok` in the request cycle).
- Miss latency: request at cycle T. FILL is entered and `creq.valid` rises at T+1. The last beat is accepted at T+k. `data_ok` is asserted at T+k+1, served by the IDLE hit path.
- With an ideal memory (`ready` every cycle, BEATS = 4), k = 4, so the miss costs 5 cycles.
- `creq` fields are constant for the whole burst. `creq.valid` drops on the edge after `last`.
- At most one outstanding burst. No request is accepted (`addr_ok = 0`) while in FILL.

## Test plan
- Cold miss:
  - Stimulus: after reset, `ireq` = {1, 0x8000_0004}. Memory returns beats 0x00000093_00000013, 0x2, 0x3, 0x4 with `ready` every cycle.
  - Required: `creq.addr` = 0x8000_0000, `len` = MLEN4, `valid` for 4 cycles. `data_ok` = 1 with `data` = 0x00000093 at T+5.
- Sequential hit:
  - Stimulus: `ireq.addr` 0x8000_0000, then 0x8000_0008.
  - Required: `data_ok` in the same cycle each time, `data` = 0x00000013 then 0x2. `creq.valid` stays 0.
- Line replacement:
  - Stimulus: `ireq.addr` 0x8000_0020.
  - Required: a new burst at 0x8000_0020 is issued. A later request to 0x8000_0000 misses again.
- Backpressure:
  - Stimulus: `ready` pattern 1,0,0,1,1,0,1 (last on the final 1).
  - Required: all 4 beats stored in order. `creq` is stable through the gaps. `data_ok` comes one cycle after the final beat.
- Flush mid-fill:
  - Stimulus: pulse `flush` on the second beat.
  - Required: the burst completes. The same address then misses and refetches, with no `data_ok` before the second burst ends.
- Async reset mid-fill:
  - Stimulus: drop `resetn` between clock edges during FILL.
  - Required: `creq.valid` and `iresp.data_ok` go to 0 without waiting for a clock edge. After release, the first request misses.
